// File: rtl/display_pkg.sv
// Shared symbol codes and controller state encoding for the seven-segment display path.
package display_pkg;

    localparam int unsigned SYM_W = 5;

    localparam logic [SYM_W-1:0] CODE_BLANK = 5'h1F;
    localparam logic [SYM_W-1:0] CODE_G     = 5'h10;
    localparam logic [SYM_W-1:0] CODE_H     = 5'h11;
    localparam logic [SYM_W-1:0] CODE_I     = 5'h13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        PAUSE  = 2'd2
    } state_t;

endpackage

// File: rtl/scroll_display_ctrl_tick_gen.sv
// Modulo-MODULO counter with synchronous clear and enable; tick_c flags the terminal count.
module tick_gen #(
    parameter int unsigned MODULO = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CW = (MODULO > 1) ? $clog2(MODULO) : 1;
    localparam logic [CW-1:0] LAST = CW'(MODULO - 1);

    logic [CW-1:0] count;

    // Terminal flag is ungated; the user qualifies it with its own enable.
    assign tick_c = (count == LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick_c ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolls a stored symbol message across N_DIG seven-segment digits.
// Optional SCROLL_BLINK_EN: blink the frozen window on/off while paused.
module scroll_display_ctrl
    import display_pkg::*;
#(
    parameter int unsigned MSG_LEN        = 8,
    parameter int unsigned N_DIG          = 6,
    parameter int unsigned TICKS_PER_STEP = 50_000_000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [SYM_W-1:0]           wr_data,
    output logic                       wr_ack,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
    output logic [SYM_W*N_DIG-1:0]     code_out,
    output logic [$clog2(MSG_LEN)-1:0] pos,
    output logic                       busy,
    output logic                       step_pulse
);

    localparam int unsigned AW    = $clog2(MSG_LEN);
    localparam int unsigned OUT_W = SYM_W * N_DIG;
    localparam logic [OUT_W-1:0] ALL_BLANK = {N_DIG{CODE_BLANK}};

    state_t               state_q, state_d;
    logic [AW-1:0]        pos_q, pos_d;
    logic                 step_q, step_d;
    logic [SYM_W-1:0]     msg [MSG_LEN];
    logic                 wr_accept_c;
    logic                 cnt_en_c, cnt_clr_c, step_term_c;
    logic                 pause_show_c;
    logic [OUT_W-1:0]     window_c, code_c;

    assign cnt_en_c    = (state_q == SCROLL) && !clear && !stop;
    assign cnt_clr_c   = clear || (state_q == IDLE);
    assign wr_accept_c = wr_en && !clear && ((state_q == IDLE) || (state_q == PAUSE));

    tick_gen #(.MODULO(TICKS_PER_STEP)) u_step_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (cnt_clr_c),
        .en     (cnt_en_c),
        .tick_c (step_term_c)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and window position; clear outranks stop, which outranks start.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            pos_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_d = SCROLL;
                        pos_d   = '0;
                    end
                end
                SCROLL: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (step_term_c) begin
                        pos_d  = pos_q + AW'(1);
                        step_d = 1'b1;
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        state_d = SCROLL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pos_q  <= '0;
            step_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            step_q <= step_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg[i] <= CODE_BLANK;
            end
        end else if (wr_accept_c) begin
            msg[wr_addr] <= wr_data;
        end
    end

`ifdef SCROLL_BLINK_EN
    logic blink_term_c;
    logic blank_phase;

    tick_gen #(.MODULO(TICKS_PER_STEP)) u_blink_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (state_q != PAUSE),
        .en     (state_q == PAUSE),
        .tick_c (blink_term_c)
    );

    // Window phase first on entering PAUSE, then alternate every TICKS_PER_STEP cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            blank_phase <= 1'b0;
        end else if (state_q != PAUSE) begin
            blank_phase <= 1'b0;
        end else if (blink_term_c) begin
            blank_phase <= !blank_phase;
        end
    end

    assign pause_show_c = !blank_phase;
`else
    assign pause_show_c = 1'b1;
`endif

    // Leftmost digit (slice N_DIG-1) shows msg[pos]; indices wrap modulo MSG_LEN.
    always_comb begin
        window_c = ALL_BLANK;
        for (int k = 0; k < N_DIG; k++) begin
            window_c[SYM_W*k +: SYM_W] = msg[AW'(pos_q + AW'(N_DIG - 1 - k))];
        end
    end

    always_comb begin
        code_c = ALL_BLANK;
        if (state_q == SCROLL) begin
            code_c = window_c;
        end else if ((state_q == PAUSE) && pause_show_c) begin
            code_c = window_c;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            code_out   <= ALL_BLANK;
            pos        <= '0;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            wr_ack     <= 1'b0;
        end else begin
            code_out   <= code_c;
            pos        <= pos_q;
            busy       <= (state_q == SCROLL);
            step_pulse <= step_q;
            wr_ack     <= wr_accept_c;
        end
    end

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Directed self-checking bench for scroll_display_ctrl (TICKS_PER_STEP=4, MSG_LEN=8, N_DIG=6).
module tb_scroll_display_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [4:0]  wr_data;
    logic        wr_ack;
    logic        start, stop, clear;
    logic [29:0] code_out;
    logic [2:0]  pos;
    logic        busy;
    logic        step_pulse;

    int checks   = 0;
    int failures = 0;

    logic [4:0] model [8];

    scroll_display_ctrl #(
        .MSG_LEN(8),
        .N_DIG(6),
        .TICKS_PER_STEP(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .code_out   (code_out),
        .pos        (pos),
        .busy       (busy),
        .step_pulse (step_pulse)
    );

    always #5 clock = ~clock;

    function automatic logic [29:0] mk(input logic [4:0] a5, a4, a3, a2, a1, a0);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [29:0] exp_win(input int p);
        logic [29:0] w;
        for (int k = 0; k < 6; k++) w[5*k +: 5] = model[(p + 5 - k) % 8];
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 5'h1F;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checks++;
            if (wr_ack !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_flags: cycle %0d wr_ack=%b busy=%b required 0 0", c, wr_ack, busy);
            end
        end
        checks++;
        if (code_out !== 30'h3FFF_FFFF) begin
            failures++; $display("FAIL reset_code_out: got %h required %h", code_out, 30'h3FFF_FFFF);
        end
        checks++;
        if (pos !== 3'd0 || step_pulse !== 1'b0) begin
            failures++; $display("FAIL reset_pos_step: pos=%0d step=%b required 0 0", pos, step_pulse);
        end
    endtask

    task automatic test_write();
        logic [4:0] d [8];
        d = '{5'h0, 5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 5'h10, 5'h11};
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = d[i];
            @(negedge clock);
            model[i] = d[i];
            checks++;
            if (wr_ack !== 1'b1) begin
                failures++; $display("FAIL write_ack_idle: addr %0d wr_ack=%b required 1", i, wr_ack);
            end
        end
        wr_en = 1'b0;
        @(negedge clock);
        checks++;
        if (wr_ack !== 1'b0 || code_out !== 30'h3FFF_FFFF) begin
            failures++;
            $display("FAIL write_idle_after: wr_ack=%b code=%h required 0 %h", wr_ack, code_out, 30'h3FFF_FFFF);
        end
    endtask

    task automatic test_scroll();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL start_latency: busy=%b required 0", busy);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || pos !== 3'd0 || step_pulse !== 1'b0 || code_out !== mk(0, 1, 2, 3, 4, 5)) begin
            failures++;
            $display("FAIL first_window: busy=%b pos=%0d step=%b code=%h required 1 0 0 %h",
                     busy, pos, step_pulse, code_out, mk(0, 1, 2, 3, 4, 5));
        end
        for (int c = 1; c <= 32; c++) begin
            wr_en = (c == 6); wr_addr = 3'd0; wr_data = 5'h9;
            @(negedge clock);
            wr_en = 1'b0;
            if (c == 6) begin
                checks++;
                if (wr_ack !== 1'b0) begin
                    failures++; $display("FAIL scroll_write_dropped: wr_ack=%b required 0", wr_ack);
                end
            end
            if (c == 4) begin
                checks++;
                if (code_out !== mk(1, 2, 3, 4, 5, 5'h10)) begin
                    failures++; $display("FAIL second_window: got %h required %h", code_out, mk(1, 2, 3, 4, 5, 5'h10));
                end
            end
            if (c % 4 == 0) begin
                checks++;
                if (step_pulse !== 1'b1 || pos !== 3'((c / 4) % 8) || code_out !== exp_win((c / 4) % 8)) begin
                    failures++;
                    $display("FAIL step_%0d: step=%b pos=%0d code=%h required 1 %0d %h",
                             c / 4, step_pulse, pos, code_out, (c / 4) % 8, exp_win((c / 4) % 8));
                end
            end else if (c == 5) begin
                checks++;
                if (step_pulse !== 1'b0) begin
                    failures++; $display("FAIL step_pulse_width: step=%b required 0", step_pulse);
                end
            end
        end
        checks++;
        if (code_out[29:25] !== 5'h0) begin
            failures++; $display("FAIL wrap_entry0_unchanged: got %h required 00", code_out[29:25]);
        end
    endtask

    task automatic test_pause();
        repeat (8) @(negedge clock);
        checks++;
        if (pos !== 3'd2 || step_pulse !== 1'b1) begin
            failures++; $display("FAIL pre_stop_pos: pos=%0d step=%b required 2 1", pos, step_pulse);
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'hA;
        @(negedge clock);
        wr_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || wr_ack !== 1'b1 || code_out !== mk(2, 3, 4, 5, 5'h10, 5'h11)) begin
            failures++;
            $display("FAIL pause_write_ack: busy=%b wr_ack=%b code=%h required 0 1 %h",
                     busy, wr_ack, code_out, mk(2, 3, 4, 5, 5'h10, 5'h11));
        end
        model[3] = 5'hA;
        @(negedge clock);
        checks++;
        if (code_out !== mk(2, 5'hA, 4, 5, 5'h10, 5'h11) || wr_ack !== 1'b0 || pos !== 3'd2) begin
            failures++;
            $display("FAIL pause_write_visible: code=%h wr_ack=%b pos=%0d required %h 0 2",
                     code_out, wr_ack, pos, mk(2, 5'hA, 4, 5, 5'h10, 5'h11));
        end
        repeat (3) @(negedge clock);
        checks++;
`ifdef SCROLL_BLINK_EN
        if (code_out !== 30'h3FFF_FFFF || pos !== 3'd2) begin
            failures++; $display("FAIL pause_blank_phase: code=%h pos=%0d required %h 2", code_out, pos, 30'h3FFF_FFFF);
        end
`else
        if (code_out !== mk(2, 5'hA, 4, 5, 5'h10, 5'h11) || pos !== 3'd2) begin
            failures++;
            $display("FAIL pause_steady: code=%h pos=%0d required %h 2", code_out, pos, mk(2, 5'hA, 4, 5, 5'h10, 5'h11));
        end
`endif
        repeat (4) @(negedge clock);
        checks++;
        if (code_out !== mk(2, 5'hA, 4, 5, 5'h10, 5'h11) || step_pulse !== 1'b0) begin
            failures++;
            $display("FAIL pause_window_again: code=%h step=%b required %h 0", code_out, step_pulse, mk(2, 5'hA, 4, 5, 5'h10, 5'h11));
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || pos !== 3'd2) begin
            failures++; $display("FAIL resume_pos: busy=%b pos=%0d required 1 2", busy, pos);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (step_pulse !== 1'b1 || pos !== 3'd3 || code_out !== mk(5'hA, 4, 5, 5'h10, 5'h11, 0)) begin
            failures++;
            $display("FAIL resume_counter_kept: step=%b pos=%0d code=%h required 1 3 %h",
                     step_pulse, pos, code_out, mk(5'hA, 4, 5, 5'h10, 5'h11, 0));
        end
    endtask

    task automatic test_clear();
        clear = 1'b1; stop = 1'b1; start = 1'b1;
        @(negedge clock);
        clear = 1'b0; stop = 1'b0; start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || pos !== 3'd0 || code_out !== 30'h3FFF_FFFF || step_pulse !== 1'b0) begin
            failures++;
            $display("FAIL clear_priority: busy=%b pos=%0d code=%h step=%b required 0 0 %h 0",
                     busy, pos, code_out, step_pulse, 30'h3FFF_FFFF);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || code_out !== 30'h3FFF_FFFF) begin
            failures++; $display("FAIL clear_msg_blank: busy=%b code=%h required 1 %h", busy, code_out, 30'h3FFF_FFFF);
        end
    endtask

    task automatic test_clear_write();
        clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h5;
        @(negedge clock);
        clear = 1'b0; wr_en = 1'b0;
        checks++;
        if (wr_ack !== 1'b0) begin
            failures++; $display("FAIL clear_discards_write_ack: wr_ack=%b required 0", wr_ack);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (code_out[29:25] !== 5'h1F) begin
            failures++; $display("FAIL clear_discards_write_data: got %h required 1f", code_out[29:25]);
        end
    endtask

    task automatic test_back_to_back();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h13;
        @(negedge clock);
        checks++;
        if (wr_ack !== 1'b1) begin
            failures++; $display("FAIL b2b_ack0: wr_ack=%b required 1", wr_ack);
        end
        wr_addr = 3'd1; wr_data = 5'h1E;
        @(negedge clock);
        wr_en = 1'b0;
        checks++;
        if (wr_ack !== 1'b1) begin
            failures++; $display("FAIL b2b_ack1: wr_ack=%b required 1", wr_ack);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (code_out !== mk(5'h13, 5'h1E, 5'h1F, 5'h1F, 5'h1F, 5'h1F)) begin
            failures++;
            $display("FAIL b2b_window: got %h required %h", code_out, mk(5'h13, 5'h1E, 5'h1F, 5'h1F, 5'h1F, 5'h1F));
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) @(negedge clock);
        reset = 1'b0; start = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'h7;
        @(negedge clock);
        reset = 1'b1; start = 1'b0; wr_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || pos !== 3'd0 || code_out !== 30'h3FFF_FFFF || wr_ack !== 1'b0 || step_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_scroll: busy=%b pos=%0d code=%h ack=%b step=%b required 0 0 %h 0 0",
                     busy, pos, code_out, wr_ack, step_pulse, 30'h3FFF_FFFF);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || code_out !== 30'h3FFF_FFFF) begin
            failures++; $display("FAIL reset_mid_msg: busy=%b code=%h required 1 %h", busy, code_out, 30'h3FFF_FFFF);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_scroll();
        test_pause();
        test_clear();
        test_clear_write();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/scroll_display_ctrl.md
# scroll_display_ctrl

Controller that stores a short message of 5-bit display symbols and scrolls it across a bank of seven-segment digits at a fixed rate. It sits between the experiment's control unit and the per-digit `hexa7seg` decoders. It produces one registered 5-bit symbol per digit and sequences which message window is shown. Symbols use the decoder's code space: 0x0–0xF hex, 0x10 'g', 0x11 'h', 0x13 'i', and any unlisted code (0x1F used) blank.

## Interface
- `MSG_LEN`, 8 — message length in symbols (power of two, ≥ `N_DIG`)
- `N_DIG`, 6 — number of digits driven
- `TICKS_PER_STEP`, 50_000_000 — clock cycles per scroll step (1 s at 50 MHz)
- `clock`  in  1  — single clock, rising edge
- `reset`  in  1  — synchronous, active-low reset
- `wr_en`  in  1  — write request for one message symbol
- `wr_addr`  in  $clog2(MSG_LEN)  — symbol index
- `wr_data`  in  5  — symbol code
- `wr_ack`  out  1  — one-cycle pulse: write accepted
- `start`  in  1  — begin scrolling, or resume from pause
- `stop`  in  1  — pause scrolling
- `clear`  in  1  — return to idle and blank the whole message
- `code_out`  out  5*N_DIG  — slice k (`[5k+4:5k]`) feeds digit k; k=N_DIG-1 is leftmost
- `pos`  out  $clog2(MSG_LEN)  — current window start index
- `busy`  out  1  — high in SCROLL
- `step_pulse`  out  1  — one-cycle pulse on each window advance

## Operation
- States: IDLE, SCROLL, PAUSE.
- Reset values:
  - state IDLE; all message entries 0x1F.
  - `pos`=0 and tick counter=0.
  - `code_out` all 0x1F; `wr_ack`, `busy`, `step_pulse` all 0.
- IDLE:
  - `code_out` is all blank.
  - `start` → SCROLL with `pos`=0 and counter=0.
- SCROLL:
  - Slice k = msg[(pos + N_DIG-1-k) mod MSG_LEN]; the leftmost digit shows msg[pos].
  - The counter increments every cycle. When it equals TICKS_PER_STEP-1: it resets to 0, `pos` increments, and `pos` wraps from MSG_LEN-1 to 0.
  - `stop` → PAUSE.
- PAUSE:
  - Window, `pos` and counter are frozen.
  - `start` → SCROLL, resuming with the same `pos` and counter value.
- Writes:
  - Accepted only in IDLE and PAUSE; `wr_ack` is high the cycle after an accepted write.
  - Writes in SCROLL are dropped, with no `wr_ack`.
  - In PAUSE, a written symbol inside the window appears on `code_out` the cycle after the write.
- Priority when inputs coincide, highest first: `clear` > `stop` > `start`. `clear` in the same cycle as `wr_en` discards the write.
- `clear` from any state → IDLE. It sets all entries to 0x1F, `pos`=0, counter=0.
- Symbols are stored verbatim; codes not in the decoder table simply display blank.

## Timing
- All outputs are registered.
- `start` sampled at edge t:
  - `busy`=1 and the window for `pos`=0 are visible after edge t+1's update, i.e. one cycle latency.
- First advance comes TICKS_PER_STEP cycles after entering SCROLL.
  - `step_pulse` is high in exactly the cycle in which the new `pos` and window first appear.
- Writes: `wr_en` at edge t → memory updated and `wr_ack`=1 during cycle t+1.
- `stop` at edge t → `busy`=0 from t+1. No step occurs at t even if the counter terminal coincides.
- `reset` low at any edge overrides everything, including mid-step and mid-write.

## Configuration
- `SCROLL_BLINK_EN`:
  - Defined: in PAUSE, `code_out` alternates between the frozen window and all-blank. Each phase lasts TICKS_PER_STEP cycles, and the window phase comes first on entry. A separate blink counter runs only in PAUSE and is zeroed on entry.
  - Undefined: PAUSE shows a steady window, and no blink counter is synthesized.

## Structure
- Shared package `display_pkg` holds:
  - symbol constants: CODE_BLANK=5'h1F, CODE_G=5'h10, CODE_H=5'h11, CODE_I=5'h13;
  - the state encoding (IDLE/SCROLL/PAUSE).
- One sub-module, `tick_gen`:
  - parameterised modulo counter with synchronous clear and enable;
  - emits a terminal-count strobe;
  - reused for the blink timer.
- Message storage is a register array with combinational window indexing into output registers.

## Test plan
Bench uses TICKS_PER_STEP=4, MSG_LEN=8, N_DIG=6.
- Reset, then idle 10 cycles → `code_out`=all 0x1F, `busy`=0, `pos`=0, no `wr_ack`.
- Write msg = 0,1,2,3,4,5,0x10,0x11, then `start`:
  - → leftmost..rightmost = 0,1,2,3,4,5;
  - after 4 cycles `step_pulse`=1 with 1,2,3,4,5,0x10;
  - after 8 steps total `pos` wraps to 0.
- `wr_en` (addr 0, data 0x9) during SCROLL → no `wr_ack`, entry 0 unchanged at the next wrap.
- `stop` at `pos`=2, write addr 3 = 0xA, then `start` → window shows 0xA at digit 4 the cycle after the write; scrolling resumes without a `pos` reset.
- `clear`+`stop`+`start` asserted together in SCROLL → IDLE, all blank, `pos`=0; next `start` shows all 0x1F.
- With `SCROLL_BLINK_EN`, `stop` → window for 4 cycles, blank for 4 cycles, repeating; without it, steady window.
